// File: rtl/fpu_div_arbiter.sv
// fpu_div_arbiter
// Shares one multi-cycle floating-point divider between NUM_REQ requesters.
// A round-robin grant latches one (a, b) operand pair, the pair is sent to the
// divider over its stb/ack handshakes, and the quotient is returned on a
// shared result bus to the requester that issued it. One operation is in
// flight at a time. A watchdog bounds the time spent talking to the divider;
// on expiry the divider is reset and a quiet NaN is returned flagged as error.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_stb/req_a/req_b      per-requester operand valid and operands
//   req_ack                  one-cycle one-hot pulse: operands accepted
//   rsp_stb/rsp_z/rsp_err    one-hot result valid, shared result, timeout flag
//   rsp_ack                  per-requester result accept
//   div_a*/div_b*/div_z*     divider operand and result handshakes
//   div_rst                  divider reset pulse (two cycles) on watchdog expiry
//   busy                     high whenever not idle
//   active_id                index of the current or most recent grant
module fpu_div_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 256,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_stb,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     rsp_stb,
  output logic [31:0]            rsp_z,
  output logic                   rsp_err,
  input  logic [NUM_REQ-1:0]     rsp_ack,
  output logic [31:0]            div_a,
  output logic                   div_a_stb,
  input  logic                   div_a_ack,
  output logic [31:0]            div_b,
  output logic                   div_b_stb,
  input  logic                   div_b_ack,
  input  logic [31:0]            div_z,
  input  logic                   div_z_stb,
  output logic                   div_z_ack,
  output logic                   div_rst,
  output logic                   busy,
  output logic [IDW-1:0]         active_id
);

  localparam int          TW      = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN_Z  = 32'hFFC00000;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_A, S_SEND_B, S_WAIT_Z, S_RECOVER, S_RETURN
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     active_id_q, active_id_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] rsp_stb_q, rsp_stb_d;
  logic [31:0]        rsp_z_q, rsp_z_d;
  logic [31:0]        div_a_q, div_a_d;
  logic [31:0]        div_b_q, div_b_d;
  logic               rsp_err_q, rsp_err_d;
  logic               div_a_stb_q, div_a_stb_d;
  logic               div_b_stb_q, div_b_stb_d;
  logic               div_z_ack_q, div_z_ack_d;
  logic               div_rst_q, div_rst_d;
  logic               busy_q, busy_d;

  logic               win_vld;
  logic [IDW-1:0]     win_id;
  logic [IDW:0]       cand;
  logic               a_xfer, b_xfer, z_xfer, tmo;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Circular priority scan starting at rr_ptr; first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!win_vld && req_stb[cand[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[IDW-1:0];
      end
    end
  end

  assign a_xfer = div_a_stb_q & div_a_ack;
  assign b_xfer = div_b_stb_q & div_b_ack;
  assign z_xfer = div_z_stb & div_z_ack_q;
  assign tmo    = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rr_ptr_d    = rr_ptr_q;
    active_id_d = active_id_q;
    req_ack_d   = '0;
    rsp_stb_d   = rsp_stb_q;
    rsp_z_d     = rsp_z_q;
    rsp_err_d   = rsp_err_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    div_a_stb_d = div_a_stb_q;
    div_b_stb_d = div_b_stb_q;
    div_z_ack_d = div_z_ack_q;
    div_rst_d   = div_rst_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          div_a_d     = req_a[32*win_id +: 32];
          div_b_d     = req_b[32*win_id +: 32];
          active_id_d = win_id;
          req_ack_d   = onehot(win_id);
          div_a_stb_d = 1'b1;
          timer_d     = '0;
          state_d     = S_SEND_A;
        end
      end
      S_SEND_A, S_SEND_B, S_WAIT_Z: begin
        // Saturating: a transfer landing on the last cycle still gets one more
        // cycle in the next state before the watchdog fires.
        timer_d = tmo ? timer_q : timer_q + 1'b1;
        if (state_q == S_SEND_A && a_xfer) begin
          div_a_stb_d = 1'b0;
          div_b_stb_d = 1'b1;
          state_d     = S_SEND_B;
        end else if (state_q == S_SEND_B && b_xfer) begin
          div_b_stb_d = 1'b0;
          div_z_ack_d = 1'b1;
          state_d     = S_WAIT_Z;
        end else if (state_q == S_WAIT_Z && z_xfer) begin
          rsp_z_d     = div_z;
          rsp_err_d   = 1'b0;
          div_z_ack_d = 1'b0;
          rsp_stb_d   = onehot(active_id_q);
          state_d     = S_RETURN;
        end else if (tmo) begin
          div_a_stb_d = 1'b0;
          div_b_stb_d = 1'b0;
          div_z_ack_d = 1'b0;
          div_rst_d   = 1'b1;
          timer_d     = '0;
          state_d     = S_RECOVER;
        end
      end
      S_RECOVER: begin
        // timer counts the div_rst cycles: hold for two, then report NaN.
        if (timer_q == '0) begin
          timer_d = TW'(1);
        end else begin
          div_rst_d = 1'b0;
          rsp_z_d   = QNAN_Z;
          rsp_err_d = 1'b1;
          rsp_stb_d = onehot(active_id_q);
          state_d   = S_RETURN;
        end
      end
      S_RETURN: begin
        if (rsp_ack[active_id_q] && rsp_stb_q[active_id_q]) begin
          rsp_stb_d = '0;
          rsp_err_d = 1'b0;
          rr_ptr_d  = (active_id_q == IDW'(NUM_REQ - 1)) ? '0 : active_id_q + 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      rr_ptr_q    <= '0;
      active_id_q <= '0;
      req_ack_q   <= '0;
      rsp_stb_q   <= '0;
      rsp_z_q     <= '0;
      rsp_err_q   <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_a_stb_q <= 1'b0;
      div_b_stb_q <= 1'b0;
      div_z_ack_q <= 1'b0;
      div_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rr_ptr_q    <= rr_ptr_d;
      active_id_q <= active_id_d;
      req_ack_q   <= req_ack_d;
      rsp_stb_q   <= rsp_stb_d;
      rsp_z_q     <= rsp_z_d;
      rsp_err_q   <= rsp_err_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_a_stb_q <= div_a_stb_d;
      div_b_stb_q <= div_b_stb_d;
      div_z_ack_q <= div_z_ack_d;
      div_rst_q   <= div_rst_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign rsp_stb   = rsp_stb_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_err   = rsp_err_q;
  assign div_a     = div_a_q;
  assign div_a_stb = div_a_stb_q;
  assign div_b     = div_b_q;
  assign div_b_stb = div_b_stb_q;
  assign div_z_ack = div_z_ack_q;
  assign div_rst   = div_rst_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Testbench for fpu_div_arbiter: a behavioural divider with random handshake
// latency, scenario tasks for reset, single op, round-robin order, special
// value pass-through, watchdog recovery, result back-pressure, randomized
// traffic and reset in mid-operation.
module tb_fpu_div_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_stb = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]   req_ack, rsp_stb;
  logic [N-1:0]   rsp_ack = '0;
  logic [31:0]    rsp_z, div_a, div_b;
  logic [31:0]    div_z;
  logic           rsp_err, div_a_stb, div_b_stb, div_z_ack, div_rst, busy;
  logic           div_a_ack, div_b_ack, div_z_stb;
  logic [1:0]     active_id;

  int checks = 0;
  int errors = 0;

  logic [31:0] pa [N];
  logic [31:0] pb [N];
  int          m_ptr = 0;
  bit          m_stall = 1'b0;

  // divider model state
  logic [31:0] m_a, m_b;
  bit          m_have_a, m_have_b, a_go, b_go, z_go;
  int          m_lat, wa, wb;

  always #5 clk = ~clk;

  fpu_div_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_stb(req_stb), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
    .rsp_stb(rsp_stb), .rsp_z(rsp_z), .rsp_err(rsp_err), .rsp_ack(rsp_ack),
    .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
    .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
    .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
    .div_rst(div_rst), .busy(busy), .active_id(active_id)
  );

  // Divider stand-in: x/0 -> signed infinity, 6.0/2.0 -> 3.0, otherwise a
  // deterministic mixing function so wrong operands show up in the result.
  function automatic logic [31:0] div_fn(input logic [31:0] a, input logic [31:0] b);
    if (b[30:0] == 31'd0 && a[30:23] != 8'hFF && a[30:0] != 31'd0)
      return {a[31] ^ b[31], 31'h7F800000};
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[15:0], b[31:16]}) + 32'd1;
  endfunction

  function automatic int arb_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v[i] = 1'b1;
    return v;
  endfunction

  // Divider handshake model, evaluated on the falling edge.
  initial begin
    div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0; div_z = '0;
    m_a = '0; m_b = '0; m_have_a = 0; m_have_b = 0;
    a_go = 0; b_go = 0; z_go = 0; m_lat = 0; wa = 0; wb = 0;
    forever begin
      @(negedge clk);
      if (rst || div_rst) begin
        div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0;
        m_have_a = 0; m_have_b = 0; a_go = 0; b_go = 0; z_go = 0; wa = 0; wb = 0;
      end else begin
        if (a_go) m_have_a = 1;
        if (b_go) begin m_have_b = 1; m_lat = $urandom_range(0, 3); end
        if (z_go) begin m_have_a = 0; m_have_b = 0; div_z_stb = 1'b0; end
        div_a_ack = div_a_stb && !m_have_a && (wa >= 2 || $urandom_range(0, 2) != 0);
        wa = (div_a_stb && !div_a_ack) ? wa + 1 : 0;
        a_go = div_a_ack;
        if (a_go) m_a = div_a;
        div_b_ack = div_b_stb && m_have_a && !m_have_b && (wb >= 2 || $urandom_range(0, 2) != 0);
        wb = (div_b_stb && !div_b_ack) ? wb + 1 : 0;
        b_go = div_b_ack;
        if (b_go) m_b = div_b;
        if (m_have_b && !div_z_stb && !m_stall) begin
          if (m_lat == 0) begin div_z_stb = 1'b1; div_z = div_fn(m_a, m_b); end
          else m_lat = m_lat - 1;
        end
        z_go = div_z_stb && div_z_ack;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_reqs(input logic [N-1:0] stb);
    req_stb = stb;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = pa[i];
      req_b[32*i +: 32] = pb[i];
    end
  endtask

  task automatic wait_ack(output logic [N-1:0] v);
    v = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin v = req_ack; return; end
    end
  endtask

  task automatic wait_rsp(output logic [N-1:0] v);
    v = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_stb != '0) begin v = rsp_stb; return; end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({req_ack, rsp_stb, rsp_err, div_a_stb, div_b_stb, div_z_ack, div_rst, busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got %h want 0",
               {req_ack, rsp_stb, rsp_err, div_a_stb, div_b_stb, div_z_ack, div_rst, busy});
    end
    checks++;
    if ({rsp_z, div_a, div_b} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {rsp_z, div_a, div_b});
    end
    checks++;
    if (active_id !== 2'd0) begin
      errors++; $display("FAIL reset_active_id: got %0d want 0", active_id);
    end
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_single();
    logic [N-1:0] v;
    pa[1] = 32'h40C00000; pb[1] = 32'h40000000;
    drive_reqs(4'b0010);
    tick();
    checks++;
    if (req_ack !== 4'b0010) begin
      errors++; $display("FAIL single_req_ack: got %b want 0010", req_ack);
    end
    checks++;
    if ({busy, div_a_stb, active_id} !== {1'b1, 1'b1, 2'd1} || div_a !== 32'h40C00000) begin
      errors++;
      $display("FAIL single_grant: busy %b a_stb %b id %0d div_a %h want 1 1 1 40c00000",
               busy, div_a_stb, active_id, div_a);
    end
    req_stb = '0;
    wait_rsp(v);
    checks++;
    if (v !== 4'b0010 || rsp_z !== 32'h40400000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: stb %b z %h err %b want 0010 40400000 0", v, rsp_z, rsp_err);
    end
    rsp_ack = 4'b0010;
    tick();
    checks++;
    if (rsp_stb !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: rsp_stb %b busy %b want 0 0", rsp_stb, busy);
    end
    rsp_ack = '0;
    m_ptr = 2;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] v;
    int exp;
    rst = 1'b1; tick(); rst = 1'b0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
    drive_reqs('1);
    rsp_ack = '1;
    for (int k = 0; k < 5; k++) begin
      exp = k % N;
      wait_ack(v);
      checks++;
      if (v !== oh(exp) || active_id !== 2'(exp)) begin
        errors++;
        $display("FAIL rr_grant%0d: ack %b id %0d want %b %0d", k, v, active_id, oh(exp), exp);
      end
      wait_rsp(v);
      checks++;
      if (v !== oh(exp) || rsp_z !== div_fn(pa[exp], pb[exp])) begin
        errors++;
        $display("FAIL rr_rsp%0d: stb %b z %h want %b %h", k, v, rsp_z, oh(exp),
                 div_fn(pa[exp], pb[exp]));
      end
      m_ptr = (exp + 1) % N;
    end
    req_stb = '0;
    tick();
    rsp_ack = '0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rr_idle: busy %b want 0", busy);
    end
  endtask

  task automatic test_div_special();
    logic [N-1:0] v;
    pa[2] = 32'h3F800000; pb[2] = 32'h00000000;
    drive_reqs(4'b0100);
    wait_ack(v);
    req_stb = '0;
    wait_rsp(v);
    checks++;
    if (v !== 4'b0100 || rsp_z !== 32'h7F800000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL special_inf: stb %b z %h err %b want 0100 7f800000 0", v, rsp_z, rsp_err);
    end
    rsp_ack = 4'b0100; tick(); rsp_ack = '0;
    m_ptr = 3;
  endtask

  task automatic test_timeout();
    logic [N-1:0] v;
    int first, cnt;
    m_stall = 1'b1;
    pa[3] = $urandom; pb[3] = $urandom;
    drive_reqs(4'b1000);
    wait_ack(v);
    req_stb = '0;
    checks++;
    if (v !== 4'b1000) begin
      errors++; $display("FAIL tmo_grant: ack %b want 1000", v);
    end
    first = -1; cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (div_rst) begin
        if (first < 0) first = c;
        cnt++;
      end
      if (rsp_stb != '0) break;
    end
    checks++;
    if (first != TMO || cnt != 2) begin
      errors++;
      $display("FAIL tmo_div_rst: first %0d len %0d want %0d 2", first, cnt, TMO);
    end
    checks++;
    if (rsp_stb !== 4'b1000 || rsp_z !== 32'hFFC00000 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_rsp: stb %b z %h err %b want 1000 ffc00000 1", rsp_stb, rsp_z, rsp_err);
    end
    m_stall = 1'b0;
    rsp_ack = 4'b1000; tick(); rsp_ack = '0;
    m_ptr = 0;
    pa[1] = $urandom; pb[1] = $urandom;
    drive_reqs(4'b0010);
    wait_ack(v);
    req_stb = '0;
    wait_rsp(v);
    checks++;
    if (v !== 4'b0010 || rsp_z !== div_fn(pa[1], pb[1]) || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after: stb %b z %h err %b want 0010 %h 0", v, rsp_z, rsp_err,
               div_fn(pa[1], pb[1]));
    end
    rsp_ack = 4'b0010; tick(); rsp_ack = '0;
    m_ptr = 2;
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] v;
    int exp, bad;
    for (int i = 0; i < N; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
    drive_reqs('1);
    exp = arb_pick('1, m_ptr);
    wait_ack(v);
    wait_rsp(v);
    checks++;
    if (v !== oh(exp) || rsp_z !== div_fn(pa[exp], pb[exp])) begin
      errors++;
      $display("FAIL bp_rsp: stb %b z %h want %b %h", v, rsp_z, oh(exp), div_fn(pa[exp], pb[exp]));
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      rsp_ack = oh((exp + 1) % N) | oh((exp + 2) % N);
      tick();
      if (div_a_stb || req_ack != '0 || rsp_stb !== oh(exp) || !busy ||
          rsp_z !== div_fn(pa[exp], pb[exp])) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: %0d bad cycles want 0", bad);
    end
    rsp_ack = oh(exp);
    tick();
    rsp_ack = '0;
    checks++;
    if (rsp_stb !== '0) begin
      errors++; $display("FAIL bp_release: rsp_stb %b want 0", rsp_stb);
    end
    m_ptr = (exp + 1) % N;
    exp = m_ptr;
    wait_ack(v);
    req_stb = '0;
    checks++;
    if (v !== oh(exp)) begin
      errors++; $display("FAIL bp_next_grant: ack %b want %b", v, oh(exp));
    end
    wait_rsp(v);
    rsp_ack = oh(exp); tick(); rsp_ack = '0;
    m_ptr = (exp + 1) % N;
  endtask

  task automatic test_random();
    logic [N-1:0] pend, v;
    logic [31:0] ea, eb;
    int exp, dly;
    pend = '0;
    for (int op = 0; op < 25; op++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1; pa[i] = $urandom; pb[i] = $urandom;
        end
      end
      if (pend == '0) begin
        exp = $urandom_range(0, N - 1);
        pend[exp] = 1'b1; pa[exp] = $urandom; pb[exp] = $urandom;
      end
      drive_reqs(pend);
      exp = arb_pick(pend, m_ptr);
      ea = pa[exp]; eb = pb[exp];
      wait_ack(v);
      checks++;
      if (v !== oh(exp)) begin
        errors++; $display("FAIL rnd_grant%0d: ack %b want %b", op, v, oh(exp));
      end
      pend[exp] = 1'b0;
      pa[exp] = $urandom; pb[exp] = $urandom;
      drive_reqs(pend);
      wait_rsp(v);
      checks++;
      if (v !== oh(exp) || rsp_z !== div_fn(ea, eb) || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL rnd_rsp%0d: stb %b z %h err %b want %b %h 0", op, v, rsp_z, rsp_err,
                 oh(exp), div_fn(ea, eb));
      end
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        rsp_ack = N'($urandom) & ~oh(exp);
        tick();
      end
      rsp_ack = oh(exp) | N'($urandom);
      tick();
      rsp_ack = '0;
      checks++;
      if (rsp_stb !== '0) begin
        errors++; $display("FAIL rnd_release%0d: rsp_stb %b want 0", op, rsp_stb);
      end
      m_ptr = (exp + 1) % N;
    end
    req_stb = '0;
    tick();
    if (busy) begin
      v = '0;
      wait_rsp(v);
      rsp_ack = v; tick(); rsp_ack = '0;
    end
  endtask

  task automatic test_rst_midop();
    logic [N-1:0] v;
    int seen;
    pa[1] = $urandom; pb[1] = $urandom;
    drive_reqs(4'b0010);
    wait_ack(v);
    req_stb = '0;
    wait_rsp(v);
    rsp_ack = 4'b0010; tick(); rsp_ack = '0;
    m_stall = 1'b1;
    pa[3] = $urandom; pb[3] = $urandom;
    drive_reqs(4'b1000);
    wait_ack(v);
    req_stb = '0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (div_z_ack) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL rst_reach_wait_z: div_z_ack never seen, got %0d want 1", seen);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_stall = 1'b0;
    checks++;
    if ({req_ack, rsp_stb, rsp_err, div_a_stb, div_b_stb, div_z_ack, div_rst, busy} !== '0 ||
        {rsp_z, div_a, div_b} !== '0 || active_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_midop_state: ctl %h data %h id %0d want 0 0 0",
               {req_ack, rsp_stb, rsp_err, div_a_stb, div_b_stb, div_z_ack, div_rst, busy},
               {rsp_z, div_a, div_b}, active_id);
    end
    m_ptr = 0;
    pa[0] = $urandom; pb[0] = $urandom;
    pa[3] = $urandom; pb[3] = $urandom;
    drive_reqs(4'b1001);
    wait_ack(v);
    req_stb = '0;
    checks++;
    if (v !== 4'b0001) begin
      errors++; $display("FAIL rst_first_grant: ack %b want 0001", v);
    end
    wait_rsp(v);
    checks++;
    if (v !== 4'b0001 || rsp_z !== div_fn(pa[0], pb[0])) begin
      errors++;
      $display("FAIL rst_after_rsp: stb %b z %h want 0001 %h", v, rsp_z, div_fn(pa[0], pb[0]));
    end
    rsp_ack = 4'b0001; tick(); rsp_ack = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_div_special();
    test_timeout();
    test_back_pressure();
    test_random();
    test_rst_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "time limit");
  end

endmodule
